osc_spi_core: RTL and testbench
===============================

# osc_spi_core

Control-to-audio core of the oscillator FPGA. Receives a 16-bit frequency word from an external ADC-side SPI master, runs a DDS phase accumulator at a fixed sample rate and streams a 12-bit sawtooth sample per tick to an MCP4822-style SPI DAC. Sits directly under the board top, clocked by the on-chip oscillator (nominal 133 MHz).

## Interface
- `SPI_TIMEOUT`, 1000: idle clocks after the last input SPI rising edge before a partial word is discarded.
- `DAC_HALF`, 4: clocks per half period of `dac_spi_clock`.
- `SAMPLE_PERIOD`, 512: clocks between sample ticks. Must be greater than 34*`DAC_HALF`+2.
- `fpga_clock` input 1: system clock.
- `reset` input 1: reset. Asynchronous and active-high; clears all state.
- `adc_spi_clock` input 1: external SPI clock. Asynchronous to `fpga_clock`, roughly 750 ns period. There is no chip select.
- `adc_spi_data` input 1: external SPI data, MSB first, valid at the `adc_spi_clock` rising edge.
- `dac_spi_cs` output 1: DAC chip select, active low.
- `dac_spi_clock` output 1: DAC SPI clock, mode 0.
- `dac_spi_data` output 1: DAC SPI data, MSB first.

## Operation
- Input receiver:
  - 2-flop synchronisers on `adc_spi_clock` and `adc_spi_data`.
  - A rising edge is detected on the synchronised clock (previous 0, current 1).
  - On each edge, shift the synchronised data into a 16-bit shift register (MSB first) and increment a 4-bit bit counter.
  - When the 16th bit arrives, load `freq_word` with the complete word in the same cycle and clear the bit counter.
- Timeout:
  - An idle counter is cleared on each detected edge and otherwise increments, saturating.
  - When it reaches `SPI_TIMEOUT`, clear the bit counter so the partial word is dropped. `freq_word` is unchanged.
- DDS:
  - A sample counter produces a one-cycle `tick` every `SAMPLE_PERIOD` clocks.
  - On `tick`, capture `sample = phase[31:20]`, then update `phase <= phase + {12'd0, freq_word, 4'd0}`.
  - Addition is mod 2^32 (natural wrap).
- DAC transmitter, FSM IDLE → SHIFT → DONE → IDLE:
  - IDLE: `dac_spi_cs`=1, `dac_spi_clock`=0. On `tick`, load frame = {4'b0011, sample} (channel A, gain 1x, active), drive the MSB on `dac_spi_data`, set `dac_spi_cs`=0 and go to SHIFT.
  - SHIFT: toggle `dac_spi_clock` every `DAC_HALF` clocks for 16 clock pulses. Data changes only on falling edges; the DAC samples on rising edges.
  - DONE: after the 16th falling edge, hold for one `DAC_HALF`, then set `dac_spi_cs`=1 and `dac_spi_data`=0 and return to IDLE.
  - A `tick` arriving outside IDLE is ignored. The parameter constraint guarantees this cannot happen.
- Reset values:
  - All-zero: `phase`, `freq_word`, shift register, bit counter, idle counter, sample counter.
  - Outputs: `dac_spi_cs`=1, `dac_spi_clock`=0, `dac_spi_data`=0.
  - Reset mid-frame aborts the frame immediately.

## Timing
- Input word latency: `freq_word` updates 3 clocks after the 16th `adc_spi_clock` rising edge (2 sync stages + 1 edge-detect register).
- The first `tick` occurs `SAMPLE_PERIOD` clocks after reset release; subsequent ticks are exactly periodic.
- `dac_spi_cs` falls 1 clock after `tick`. The frame lasts 32*`DAC_HALF` clocks of SCLK activity plus a `DAC_HALF` trailing gap.
- A `freq_word` update takes effect on the next `tick`.
- Simultaneous edge and timeout in one cycle: the edge wins (counter reset and bit accepted).

## Structure
- Shared package `osc_pkg`: DAC config nibble constant 4'b0011, frame width 16, phase width 32, FSM state enum.
- One natural sub-module, `dac_spi_tx`: frame in plus start in; cs/clock/data plus busy out.
- Receiver, timeout and DDS stay inline.

## Test plan
- Reset: hold `reset`=1 for 20 ns → `dac_spi_cs`=1, `dac_spi_clock`=0, `dac_spi_data`=0, `freq_word`=0. After release, DAC frames carry 0x3000 (sample stays 0).
- Good word: send 16'hAACC at 375 ns half-periods → `freq_word`=0xAACC. The phase step per tick is 0x000AACC0. The sample sequence is 0x000, 0x000, … and the first nonzero sample appears once `phase` crosses 0x00100000.
- Truncated word recovery: send the first 15 bits of 16'h96AA, wait 10 µs, then send 16'hAACC → `freq_word`=0xAACC, not a misaligned value. No update occurs after the 15-bit packet.
- DAC frame format: with `freq_word`=0xFFFF, decode 16 bits per cs-low window on `dac_spi_clock` rising edges → top nibble 0b0011, exactly 16 rising edges, `dac_spi_cs` high between frames.
- Phase wrap: preload via words to `freq_word`=0xFFFF, run more than 4096 ticks → the sample wraps from ≥0xFF0 to a small value without glitching the frame.
- Reset mid-frame: assert `reset` during SHIFT → outputs return to idle values immediately. The next frame starts cleanly `SAMPLE_PERIOD` clocks after release.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared constants and types for the oscillator control-to-audio core.
package osc_pkg;

  localparam logic [3:0] DAC_CFG  = 4'b0011;
  localparam int         FRAME_W  = 16;
  localparam int         PHASE_W  = 32;
  localparam int         SAMPLE_W = 12;
  localparam int         FREQ_W   = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_DONE
  } tx_state_e;

endpackage

// File: rtl/dac_spi_tx.sv
// Mode-0 SPI transmitter for one 16-bit DAC frame; chip select framed,
// data launched on falling SCLK edges, one half-period trailing gap.
module dac_spi_tx
  import osc_pkg::*;
#(
  parameter int DAC_HALF = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               cs_n,
  output logic               sclk,
  output logic               sdo,
  output logic               busy
);

  localparam int              HW         = $clog2(DAC_HALF + 1);
  localparam logic [HW-1:0]   HALF_LAST  = HW'(DAC_HALF - 1);
  localparam int              PW         = $clog2(FRAME_W);
  localparam logic [PW-1:0]   PULSE_LAST = PW'(FRAME_W - 1);

  tx_state_e            state_q, state_d;
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic [HW-1:0]        half_q, half_d;
  logic [PW-1:0]        pulse_q, pulse_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic                 sdo_q, sdo_d;
  logic                 half_end;

  assign half_end = (half_q == HALF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (start) state_d = TX_SHIFT;
      TX_SHIFT: if (half_end && sclk_q && pulse_q == PULSE_LAST) state_d = TX_DONE;
      TX_DONE:  if (half_end) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // A half-period tick toggles SCLK; only the falling half advances the data.
  always_comb begin
    shreg_d = shreg_q;
    half_d  = half_q;
    pulse_d = pulse_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    case (state_q)
      TX_IDLE: begin
        half_d  = '0;
        pulse_d = '0;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
        sdo_d   = 1'b0;
        if (start) begin
          shreg_d = frame[FRAME_W-2:0];
          sdo_d   = frame[FRAME_W-1];
          cs_d    = 1'b0;
        end
      end
      TX_SHIFT: begin
        half_d = half_end ? '0 : half_q + HW'(1);
        if (half_end) begin
          sclk_d = ~sclk_q;
          if (sclk_q && pulse_q != PULSE_LAST) begin
            sdo_d   = shreg_q[FRAME_W-2];
            shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
            pulse_d = pulse_q + PW'(1);
          end
        end
      end
      TX_DONE: begin
        half_d = half_end ? '0 : half_q + HW'(1);
        if (half_end) begin
          cs_d  = 1'b1;
          sdo_d = 1'b0;
        end
      end
      default: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        sdo_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      half_q  <= '0;
      pulse_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      half_q  <= half_d;
      pulse_q <= pulse_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
    end
  end

  assign cs_n = cs_q;
  assign sclk = sclk_q;
  assign sdo  = sdo_q;
  assign busy = (state_q != TX_IDLE);

endmodule

// File: rtl/osc_spi_core.sv
// Oscillator core: SPI frequency-word receiver with idle timeout, DDS
// sawtooth phase accumulator, and a DAC frame per sample tick.
module osc_spi_core
  import osc_pkg::*;
#(
  parameter int SPI_TIMEOUT   = 1000,
  parameter int DAC_HALF      = 4,
  parameter int SAMPLE_PERIOD = 512
) (
  input  logic fpga_clock,
  input  logic reset,
  input  logic adc_spi_clock,
  input  logic adc_spi_data,
  output logic dac_spi_cs,
  output logic dac_spi_clock,
  output logic dac_spi_data
);

  localparam int            IW       = $clog2(SPI_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(SPI_TIMEOUT);
  localparam int            CW       = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);

  function automatic logic [IW-1:0] idle_sat_inc(input logic [IW-1:0] v);
    return (v == IDLE_MAX) ? v : v + IW'(1);
  endfunction

  logic                sck_p0_q, sck_p0_d, sck_p1_q, sck_p1_d, sck_p2_q, sck_p2_d;
  logic                sdi_p0_q, sdi_p0_d, sdi_p1_q, sdi_p1_d;
  logic [FREQ_W-2:0]   shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic [FREQ_W-1:0]   freq_word_q, freq_word_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                spi_edge;
  logic                tx_start, tx_busy;
  logic [FRAME_W-1:0]  tx_frame;

  // sck_p2 is the edge-detect register behind the two synchroniser stages.
  assign spi_edge = sck_p1_q & ~sck_p2_q;

  always_comb begin
    sck_p0_d    = adc_spi_clock;
    sck_p1_d    = sck_p0_q;
    sck_p2_d    = sck_p1_q;
    sdi_p0_d    = adc_spi_data;
    sdi_p1_d    = sdi_p0_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    freq_word_d = freq_word_q;
    idle_d      = idle_q;
    if (spi_edge) begin
      idle_d  = '0;
      shift_d = {shift_q[FREQ_W-3:0], sdi_p1_q};
      if (bit_cnt_q == 4'd15) begin
        freq_word_d = {shift_q, sdi_p1_q};
        bit_cnt_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      idle_d = idle_sat_inc(idle_q);
      if (idle_q == IDLE_MAX) bit_cnt_d = '0;
    end
  end

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    tick_d  = (cnt_q == CNT_LAST);
    phase_d = phase_q;
    if (tick_q) phase_d = phase_q + {{(PHASE_W-FREQ_W-4){1'b0}}, freq_word_q, 4'd0};
  end

  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      sck_p0_q    <= 1'b0;
      sck_p1_q    <= 1'b0;
      sck_p2_q    <= 1'b0;
      sdi_p0_q    <= 1'b0;
      sdi_p1_q    <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      freq_word_q <= '0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      phase_q     <= '0;
    end else begin
      sck_p0_q    <= sck_p0_d;
      sck_p1_q    <= sck_p1_d;
      sck_p2_q    <= sck_p2_d;
      sdi_p0_q    <= sdi_p0_d;
      sdi_p1_q    <= sdi_p1_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      freq_word_q <= freq_word_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      phase_q     <= phase_d;
    end
  end

  // The frame carries the phase as it stands on the tick, before the step is added.
  assign tx_frame = {DAC_CFG, phase_q[PHASE_W-1 -: SAMPLE_W]};
  assign tx_start = tick_q & ~tx_busy;

  dac_spi_tx #(
    .DAC_HALF (DAC_HALF)
  ) u_tx (
    .clk   (fpga_clock),
    .rst   (reset),
    .start (tx_start),
    .frame (tx_frame),
    .cs_n  (dac_spi_cs),
    .sclk  (dac_spi_clock),
    .sdo   (dac_spi_data),
    .busy  (tx_busy)
  );

endmodule

// File: tb/tb_osc_spi_core.sv
// Directed bench for osc_spi_core: frames decoded off the DAC pins are
// compared against a phase-accumulator reference via a scoreboard queue.
`timescale 1ns/1ps
module tb_osc_spi_core;

  localparam int P        = 80;
  localparam int H        = 2;
  localparam int TO       = 1000;
  localparam int SPI_HALF = 50;

  logic fpga_clock    = 1'b0;
  logic reset         = 1'b1;
  logic adc_spi_clock = 1'b0;
  logic adc_spi_data  = 1'b0;
  logic dac_spi_cs, dac_spi_clock, dac_spi_data;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [31:0] model_phase = '0;
  logic [31:0] model_step  = '0;
  bit          abort_pending = 1'b0;
  bit          saw_high = 1'b0;
  bit          wrap_seen = 1'b0;

  osc_spi_core #(
    .SPI_TIMEOUT   (TO),
    .DAC_HALF      (H),
    .SAMPLE_PERIOD (P)
  ) dut (
    .fpga_clock    (fpga_clock),
    .reset         (reset),
    .adc_spi_clock (adc_spi_clock),
    .adc_spi_data  (adc_spi_data),
    .dac_spi_cs    (dac_spi_cs),
    .dac_spi_clock (dac_spi_clock),
    .dac_spi_data  (dac_spi_data)
  );

  always #3.75 fpga_clock = ~fpga_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference DDS: each frame start consumes the current phase, then steps it.
  initial begin : monitor
    logic [15:0] rx;
    logic [15:0] expf;
    int          nb;
    bit          done;
    forever begin
      @(negedge dac_spi_cs);
      exp_q.push_back({4'b0011, model_phase[31:20]});
      model_phase = model_phase + model_step;
      rx   = '0;
      nb   = 0;
      done = 1'b0;
      while (!done) begin
        @(posedge dac_spi_clock or posedge dac_spi_cs);
        #1;
        if (dac_spi_cs) done = 1'b1;
        else begin
          rx = {rx[14:0], dac_spi_data};
          nb++;
        end
      end
      expf = exp_q.pop_front();
      if (abort_pending) abort_pending = 1'b0;
      else begin
        check("frame_bits", 32'(nb), 32'd16);
        check("frame_data", 32'(rx), 32'(expf));
        check("frame_cfg", 32'(rx[15:12]), 32'h3);
        check("gap_sclk", 32'(dac_spi_clock), 32'd0);
        check("gap_sdo", 32'(dac_spi_data), 32'd0);
        if (rx[11:0] >= 12'hFF0) saw_high = 1'b1;
        else if (saw_high && rx[11:0] < 12'h010) wrap_seen = 1'b1;
      end
    end
  end

  task automatic wait_frame_start(input string tag);
    int n = 0;
    while (!dac_spi_cs && n < 4*P) begin @(negedge fpga_clock); n++; end
    while (dac_spi_cs && n < 4*P) begin @(negedge fpga_clock); n++; end
    if (n >= 4*P) check({tag, "_bound"}, 32'(n), 32'(4*P - 1));
  endtask

  task automatic count_to_cs(input string tag);
    int n = 0;
    do begin
      @(posedge fpga_clock);
      #1;
      n++;
    end while (dac_spi_cs && n < 4*P);
    check(tag, 32'(n), 32'(P + 1));
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits, input bit arm);
    for (int i = 0; i < nbits; i++) begin
      adc_spi_data = w[15-i];
      repeat (SPI_HALF) @(negedge fpga_clock);
      adc_spi_clock = 1'b1;
      if (arm && i == 15) model_step = {12'd0, w, 4'd0};
      repeat (SPI_HALF) @(negedge fpga_clock);
      adc_spi_clock = 1'b0;
    end
    adc_spi_data = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #20;
    check("rst_cs", 32'(dac_spi_cs), 32'd1);
    check("rst_sclk", 32'(dac_spi_clock), 32'd0);
    check("rst_sdo", 32'(dac_spi_data), 32'd0);
    check("rst_freq", 32'(dut.freq_word_q), 32'd0);
    @(negedge fpga_clock);
    reset = 1'b0;
    count_to_cs("first_frame_delay");
    repeat (3) wait_frame_start("zero_frames");

    wait_frame_start("gw_align");
    send_bits(16'hAACC, 16, 1'b1);
    repeat (5) @(negedge fpga_clock);
    check("gw_freq", 32'(dut.freq_word_q), 32'h0000AACC);
    repeat (8) wait_frame_start("gw_run");

    wait_frame_start("tr_align");
    repeat (70) @(negedge fpga_clock);
    reset = 1'b1;
    model_phase = '0;
    model_step  = '0;
    repeat (3) @(negedge fpga_clock);
    reset = 1'b0;
    check("tr_rst_freq", 32'(dut.freq_word_q), 32'd0);
    send_bits(16'h96AA, 15, 1'b0);
    repeat (5) @(negedge fpga_clock);
    check("tr_partial", 32'(dut.freq_word_q), 32'd0);
    repeat (1334) @(negedge fpga_clock);
    check("tr_idle", 32'(dut.freq_word_q), 32'd0);
    wait_frame_start("tr_send");
    send_bits(16'hAACC, 16, 1'b1);
    repeat (5) @(negedge fpga_clock);
    check("tr_recover", 32'(dut.freq_word_q), 32'h0000AACC);
    repeat (4) wait_frame_start("tr_run");

    wait_frame_start("ff_align");
    send_bits(16'hFFFF, 16, 1'b1);
    repeat (5) @(negedge fpga_clock);
    check("ff_freq", 32'(dut.freq_word_q), 32'h0000FFFF);
    repeat (4) wait_frame_start("ff_run");

    // Jump the accumulator close to the top so the wrap is reached quickly.
    wait_frame_start("wr_align");
    repeat (5) @(negedge fpga_clock);
    dut.phase_q = 32'hFF00_0000;
    model_phase = 32'hFF00_0000;
    repeat (24) wait_frame_start("wr_run");
    check("wrap_seen", 32'(wrap_seen), 32'd1);

    wait_frame_start("mf_align");
    repeat (10) @(negedge fpga_clock);
    abort_pending = 1'b1;
    reset = 1'b1;
    #1;
    check("mf_cs", 32'(dac_spi_cs), 32'd1);
    check("mf_sclk", 32'(dac_spi_clock), 32'd0);
    check("mf_sdo", 32'(dac_spi_data), 32'd0);
    model_phase = '0;
    model_step  = '0;
    repeat (3) @(negedge fpga_clock);
    check("mf_freq", 32'(dut.freq_word_q), 32'd0);
    reset = 1'b0;
    count_to_cs("mf_restart_delay");
    repeat (3) wait_frame_start("mf_run");
    repeat (70) @(negedge fpga_clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
